// File: rtl/call_stack_ctrl.sv
// Return-address stack for the 19-bit CPU: CALL pushes the return PC, RET pops it.
// The top entry feeds the PC-next mux combinationally so fetch can redirect in the RET cycle.
module call_stack_ctrl #(
  parameter  int ADDR_W = 19,
  parameter  int DEPTH  = 8,
  localparam int PTR_W  = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic              call,
  input  logic              ret,
  input  logic [ADDR_W-1:0] pc_ret,
  input  logic              flush,
  input  logic              clr_err,
  output logic [ADDR_W-1:0] ret_addr,
  output logic              ret_valid,
  output logic              empty,
  output logic              full,
  output logic [PTR_W-1:0]  depth,
  output logic              overflow,
  output logic              underflow
);

  localparam int IDX_W = PTR_W - 1;

  logic [ADDR_W-1:0] stack_mem [DEPTH];
  logic [PTR_W-1:0]  depth_q;
  logic              overflow_q;
  logic              underflow_q;

  logic              is_empty;
  logic              is_full;
  logic [IDX_W-1:0]  wr_ptr;
  logic [IDX_W-1:0]  top_idx;
  logic [IDX_W-1:0]  wr_idx;
  logic              do_push;
  logic              do_pop;
  logic              do_replace;
  logic              set_ovf;
  logic              set_unf;
  logic              mem_we;

  // The extra depth MSB separates full (DEPTH) from empty (0) while the low
  // bits alone address the array; top_idx wraps to DEPTH-1 when full.
  assign is_empty = (depth_q == '0);
  assign is_full  = (depth_q == PTR_W'(DEPTH));
  assign wr_ptr   = depth_q[IDX_W-1:0];
  assign top_idx  = wr_ptr - IDX_W'(1);

  // NOTE: every signal assigned in this always_comb gets a default first so no latch is inferred.
  always_comb begin
    do_push    = 1'b0;
    do_pop     = 1'b0;
    do_replace = 1'b0;
    set_ovf    = 1'b0;
    set_unf    = 1'b0;
    if (en && !flush) begin
      unique case ({call, ret})
        2'b10: begin
          if (is_full) set_ovf = 1'b1;
          else         do_push = 1'b1;
        end
        2'b01: begin
          if (is_empty) set_unf = 1'b1;
          else          do_pop  = 1'b1;
        end
        2'b11: begin
          // CALL+RET on an empty stack still records the return PC.
          if (is_empty) begin
            do_push = 1'b1;
            set_unf = 1'b1;
          end else begin
            do_replace = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign wr_idx = do_replace ? top_idx : wr_ptr;
  assign mem_we = do_push | do_replace;

  // NOTE: state registers use non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      depth_q <= '0;
    end else if (flush) begin
      depth_q <= '0;
    end else if (do_push) begin
      depth_q <= depth_q + PTR_W'(1);
    end else if (do_pop) begin
      depth_q <= depth_q - PTR_W'(1);
    end
  end

  // A new error in the same cycle as clr_err wins over the clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      if (set_ovf)      overflow_q  <= 1'b1;
      else if (clr_err) overflow_q  <= 1'b0;
      if (set_unf)      underflow_q <= 1'b1;
      else if (clr_err) underflow_q <= 1'b0;
    end
  end

  // NOTE: the storage array has no reset; entries above depth are never read, so it maps to plain RAM/flops.
  always_ff @(posedge clk) begin
    if (mem_we) stack_mem[wr_idx] <= pc_ret;
  end

  assign ret_addr  = is_empty ? '0 : stack_mem[top_idx];
  assign ret_valid = !is_empty;
  assign empty     = is_empty;
  assign full      = is_full;
  assign depth     = depth_q;
  assign overflow  = overflow_q;
  assign underflow = underflow_q;

endmodule

// File: tb/tb_call_stack_ctrl.sv
// Self-checking bench for call_stack_ctrl: directed scenarios plus randomized
// traffic compared against a queue-based stack model.
module tb_call_stack_ctrl;

  localparam int ADDR_W = 19;
  localparam int DEPTH  = 8;
  localparam int PTR_W  = 4;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              en, call, ret, flush, clr_err;
  logic [ADDR_W-1:0] pc_ret;
  logic [ADDR_W-1:0] ret_addr;
  logic              ret_valid, empty, full, overflow, underflow;
  logic [PTR_W-1:0]  depth;

  int checks = 0;
  int errors = 0;

  // Reference model: a LIFO queue (back = top) plus two sticky bits.
  logic [ADDR_W-1:0] m_stack [$];
  bit                m_ovf, m_unf;

  call_stack_ctrl dut (
    .clk(clk), .rst_n(rst_n), .en(en), .call(call), .ret(ret), .pc_ret(pc_ret),
    .flush(flush), .clr_err(clr_err), .ret_addr(ret_addr), .ret_valid(ret_valid),
    .empty(empty), .full(full), .depth(depth), .overflow(overflow), .underflow(underflow)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  function automatic logic [27:0] exp_state();
    int n = m_stack.size();
    logic [ADDR_W-1:0] top = (n == 0) ? '0 : m_stack[n-1];
    return {PTR_W'(n), n == 0, n == DEPTH, n != 0, m_ovf, m_unf, top};
  endfunction

  function automatic logic [27:0] obs_state();
    return {depth, empty, full, ret_valid, overflow, underflow, ret_addr};
  endfunction

  task automatic model_reset();
    m_stack.delete();
    m_ovf = 0;
    m_unf = 0;
  endtask

  // Applies the stack rules to the inputs present at this edge.
  task automatic model_edge();
    bit so = 0, su = 0;
    int n = m_stack.size();
    if (flush) m_stack.delete();
    else if (en) begin
      if (call && !ret) begin
        if (n == DEPTH) so = 1; else m_stack.push_back(pc_ret);
      end else if (!call && ret) begin
        if (n == 0) su = 1; else void'(m_stack.pop_back());
      end else if (call && ret) begin
        if (n == 0) begin m_stack.push_back(pc_ret); su = 1; end
        else m_stack[n-1] = pc_ret;
      end
    end
    if (clr_err) begin m_ovf = 0; m_unf = 0; end
    if (so) m_ovf = 1;
    if (su) m_unf = 1;
  endtask

  task automatic apply(input logic e, input logic c, input logic r,
                       input logic [ADDR_W-1:0] pc, input logic f, input logic ce);
    en = e; call = c; ret = r; pc_ret = pc; flush = f; clr_err = ce;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    if (rst_n) model_edge();
    #1;
  endtask

  task automatic step(input logic e, input logic c, input logic r,
                      input logic [ADDR_W-1:0] pc, input logic f, input logic ce);
    apply(e, c, r, pc, f, ce);
    tick();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    en = 0; call = 0; ret = 0; pc_ret = '0; flush = 0; clr_err = 0;
    model_reset();
    #3;
    checks++;
    if (obs_state() !== {4'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 19'h0}) begin
      errors++;
      $display("FAIL reset_state: got %h expected %h", obs_state(),
               {4'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 19'h0});
    end
    #9 rst_n = 1'b1;
    tick();
    checks++;
    if (obs_state() !== exp_state()) begin
      errors++;
      $display("FAIL reset_idle: got %h expected %h", obs_state(), exp_state());
    end
  endtask

  task automatic test_push_basic();
    step(1, 1, 0, 19'h00010, 0, 0);
    checks++;
    if (depth !== 4'd1 || ret_valid !== 1'b1 || ret_addr !== 19'h00010 || empty !== 1'b0) begin
      errors++;
      $display("FAIL push_basic: depth=%0d valid=%b addr=%h empty=%b expected 1 1 00010 0",
               depth, ret_valid, ret_addr, empty);
    end
  endtask

  task automatic test_lifo();
    logic [ADDR_W-1:0] vals [3] = '{19'h00100, 19'h00200, 19'h00300};
    step(1, 0, 0, '0, 1, 0);
    for (int i = 0; i < 3; i++) step(1, 1, 0, vals[i], 0, 0);
    for (int i = 2; i >= 0; i--) begin
      apply(1, 0, 1, '0, 0, 0);
      checks++;
      if (ret_addr !== vals[i]) begin
        errors++;
        $display("FAIL lifo_pop%0d: ret_addr=%h expected %h", 2 - i, ret_addr, vals[i]);
      end
      tick();
    end
    checks++;
    if (depth !== 4'd0 || empty !== 1'b1 || underflow !== 1'b0) begin
      errors++;
      $display("FAIL lifo_final: depth=%0d empty=%b underflow=%b expected 0 1 0",
               depth, empty, underflow);
    end
    checks++;
    if (obs_state() !== exp_state()) begin
      errors++;
      $display("FAIL lifo_model: got %h expected %h", obs_state(), exp_state());
    end
  endtask

  task automatic test_overflow();
    step(1, 0, 0, '0, 1, 0);
    for (int i = 1; i <= DEPTH; i++) step(1, 1, 0, ADDR_W'(i), 0, 0);
    checks++;
    if (full !== 1'b1 || depth !== 4'd8 || overflow !== 1'b0) begin
      errors++;
      $display("FAIL fill: full=%b depth=%0d overflow=%b expected 1 8 0", full, depth, overflow);
    end
    step(1, 1, 0, 19'h00009, 0, 0);
    checks++;
    if (overflow !== 1'b1 || depth !== 4'd8 || ret_addr !== 19'h00008) begin
      errors++;
      $display("FAIL overflow: overflow=%b depth=%0d addr=%h expected 1 8 00008",
               overflow, depth, ret_addr);
    end
    step(1, 0, 0, '0, 0, 1);
    checks++;
    if (overflow !== 1'b0 || obs_state() !== exp_state()) begin
      errors++;
      $display("FAIL ovf_clear: got %h expected %h", obs_state(), exp_state());
    end
  endtask

  task automatic test_underflow();
    step(1, 0, 0, '0, 1, 0);
    apply(1, 0, 1, '0, 0, 0);
    checks++;
    if (ret_addr !== 19'h0) begin
      errors++;
      $display("FAIL empty_addr: ret_addr=%h expected 00000", ret_addr);
    end
    tick();
    checks++;
    if (underflow !== 1'b1 || depth !== 4'd0 || ret_addr !== 19'h0) begin
      errors++;
      $display("FAIL underflow: underflow=%b depth=%0d addr=%h expected 1 0 00000",
               underflow, depth, ret_addr);
    end
    step(1, 1, 1, 19'h0AAAA, 0, 0);
    checks++;
    if (depth !== 4'd1 || ret_addr !== 19'h0AAAA || underflow !== 1'b1) begin
      errors++;
      $display("FAIL callret_empty: depth=%0d addr=%h underflow=%b expected 1 0aaaa 1",
               depth, ret_addr, underflow);
    end
  endtask

  task automatic test_replace_en_flush();
    step(1, 0, 0, '0, 1, 0);
    checks++;
    if (depth !== 4'd0 || underflow !== 1'b1) begin
      errors++;
      $display("FAIL flush_keeps_flags: depth=%0d underflow=%b expected 0 1", depth, underflow);
    end
    step(1, 1, 0, 19'h00010, 0, 0);
    step(1, 1, 0, 19'h00020, 0, 0);
    step(1, 1, 0, 19'h00030, 0, 0);
    apply(1, 1, 1, 19'h00077, 0, 0);
    checks++;
    if (ret_addr !== 19'h00030) begin
      errors++;
      $display("FAIL replace_old_top: ret_addr=%h expected 00030", ret_addr);
    end
    tick();
    checks++;
    if (depth !== 4'd3 || ret_addr !== 19'h00077) begin
      errors++;
      $display("FAIL replace: depth=%0d addr=%h expected 3 00077", depth, ret_addr);
    end
    step(0, 1, 0, 19'h00055, 0, 0);
    step(0, 0, 1, 19'h00000, 0, 0);
    checks++;
    if (obs_state() !== exp_state() || depth !== 4'd3) begin
      errors++;
      $display("FAIL en_low_hold: got %h expected %h", obs_state(), exp_state());
    end
    step(1, 0, 1, '0, 0, 0);
    checks++;
    if (depth !== 4'd2 || ret_addr !== 19'h00020) begin
      errors++;
      $display("FAIL pop_after_replace: depth=%0d addr=%h expected 2 00020", depth, ret_addr);
    end
    step(0, 1, 0, 19'h00066, 1, 0);
    checks++;
    if (depth !== 4'd0 || empty !== 1'b1 || underflow !== 1'b1 || overflow !== 1'b0) begin
      errors++;
      $display("FAIL flush_en_low: depth=%0d empty=%b unf=%b ovf=%b expected 0 1 1 0",
               depth, empty, underflow, overflow);
    end
  endtask

  task automatic test_set_wins();
    step(1, 0, 1, '0, 0, 1);
    checks++;
    if (underflow !== 1'b1) begin
      errors++;
      $display("FAIL set_beats_clear: underflow=%b expected 1", underflow);
    end
    step(1, 0, 0, '0, 0, 1);
    checks++;
    if (underflow !== 1'b0) begin
      errors++;
      $display("FAIL unf_clear: underflow=%b expected 0", underflow);
    end
  endtask

  task automatic test_async_reset();
    step(1, 1, 0, 19'h01234, 0, 0);
    step(1, 1, 0, 19'h05678, 0, 0);
    step(1, 1, 1, 19'h00abc, 0, 0);
    step(1, 1, 0, 19'h00def, 0, 0);
    step(1, 0, 1, '0, 0, 0);
    checks++;
    if (depth !== 4'd2 || ret_addr !== 19'h00abc) begin
      errors++;
      $display("FAIL pre_reset: depth=%0d addr=%h expected 2 00abc", depth, ret_addr);
    end
    rst_n = 1'b0;
    #2;
    model_reset();
    checks++;
    if (obs_state() !== {4'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 19'h0}) begin
      errors++;
      $display("FAIL async_reset: got %h expected %h", obs_state(),
               {4'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 19'h0});
    end
    #2 rst_n = 1'b1;
    step(1, 0, 1, '0, 0, 0);
    checks++;
    if (underflow !== 1'b1 || depth !== 4'd0 || empty !== 1'b1) begin
      errors++;
      $display("FAIL ret_after_reset: unf=%b depth=%0d empty=%b expected 1 0 1",
               underflow, depth, empty);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 600; i++) begin
      step($urandom_range(0, 9) != 0, $urandom_range(0, 9) < 6, $urandom_range(0, 9) < 4,
           ADDR_W'($urandom), $urandom_range(0, 59) == 0, $urandom_range(0, 19) == 0);
      checks++;
      if (obs_state() !== exp_state()) begin
        errors++;
        $display("FAIL random[%0d]: got %h expected %h", i, obs_state(), exp_state());
      end
    end
  endtask

  initial begin
    test_reset();
    test_push_basic();
    test_lifo();
    test_overflow();
    test_underflow();
    test_replace_en_flush();
    test_set_wins();
    test_async_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
